// File: rtl/pinwheel_pkg.sv
// Shared types and constants for the operand fetch stage and its regfile.
package pinwheel_pkg;

    localparam int HART_BITS = 3;
    localparam int REG_BITS  = 5;
    localparam int XLEN      = 32;
    localparam int ADDR_BITS = HART_BITS + REG_BITS;
    localparam int NUM_REGS  = 1 << ADDR_BITS;

    typedef logic [ADDR_BITS-1:0] rf_addr_t;

    // Request bundle consumed by the 256-entry regfile.
    typedef struct packed {
        rf_addr_t            raddr1;
        rf_addr_t            raddr2;
        rf_addr_t            waddr;
        logic [XLEN-1:0]     wdata;
        logic                wren;
    } regfile_in;

    // One buffered instruction waiting for its operands.
    typedef struct packed {
        logic [HART_BITS-1:0] hart;
        logic [REG_BITS-1:0]  rs1;
        logic [REG_BITS-1:0]  rs2;
        logic [REG_BITS-1:0]  rd;
        logic [31:0]          pc;
    } s1_slot_t;

    // Flat regfile address of an architectural register of a hart.
    function automatic rf_addr_t rf_addr(input logic [HART_BITS-1:0] hart,
                                         input logic [REG_BITS-1:0]  rg);
        return {hart, rg};
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Pending-write scoreboard: one bit per regfile entry, set on issue of a
// writer, cleared on writeback. A simultaneous set wins since it belongs to
// the newer writer. Lookups report "still pending after this cycle's clear".
module operand_scoreboard
    import pinwheel_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     set_en_i,
    input  rf_addr_t set_addr_i,
    input  logic     clr_en_i,
    input  rf_addr_t clr_addr_i,
    input  rf_addr_t look0_addr_i,
    input  rf_addr_t look1_addr_i,
    input  rf_addr_t look2_addr_i,
    output logic [2:0] busy_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Next pending vector: apply the clear first so a same-bit set overrides it.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_addr_i] = 1'b0;
        end else begin
            pend_d = pend_d;
        end
        if (set_en_i) begin
            pend_d[set_addr_i] = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

    // Pending vector state; reset drops every outstanding write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= {NUM_REGS{1'b0}};
        end else begin
            pend_q <= pend_d;
        end
    end

    // Lookups with the clear-this-cycle bypass; the cleared value is forwarded.
    always_comb begin
        busy_o[0] = pend_q[look0_addr_i] && !(clr_en_i && (clr_addr_i == look0_addr_i));
        busy_o[1] = pend_q[look1_addr_i] && !(clr_en_i && (clr_addr_i == look1_addr_i));
        busy_o[2] = pend_q[look2_addr_i] && !(clr_en_i && (clr_addr_i == look2_addr_i));
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: buffers one instruction, reads its sources from the
// registered-read regfile, stalls on pending writes and forwards writebacks.
module operand_fetch
    import pinwheel_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [HART_BITS-1:0] in_hart,
    input  logic [REG_BITS-1:0]  in_rs1,
    input  logic [REG_BITS-1:0]  in_rs2,
    input  logic [REG_BITS-1:0]  in_rd,
    input  logic [31:0]          in_pc,
    input  logic                 wb_valid,
    input  logic [HART_BITS-1:0] wb_hart,
    input  logic [REG_BITS-1:0]  wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output regfile_in            rf_req,
    input  logic [XLEN-1:0]      rf_rs1,
    input  logic [XLEN-1:0]      rf_rs2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [HART_BITS-1:0] out_hart,
    output logic [REG_BITS-1:0]  out_rd,
    output logic [31:0]          out_pc,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data
);

    localparam logic [REG_BITS-1:0] X0 = {REG_BITS{1'b0}};

    logic            s1_valid_q;
    s1_slot_t        s1_q;
    logic            late1_q;
    logic            late2_q;
    logic [XLEN-1:0] late_data_q;

    logic            wren_s;
    rf_addr_t        wb_addr_s;
    rf_addr_t        src1_addr_s;
    rf_addr_t        src2_addr_s;
    rf_addr_t        dst_addr_s;
    logic [2:0]      busy_s;
    logic [2:0]      nonzero_s;
    logic            hazard_s;
    logic            issue_s;
    logic            accept_s;
    logic [XLEN-1:0] fwd1_s;
    logic [XLEN-1:0] fwd2_s;

    assign wren_s      = reset_n && wb_valid && (wb_rd != X0);
    assign wb_addr_s   = rf_addr(wb_hart, wb_rd);
    assign src1_addr_s = rf_addr(s1_q.hart, s1_q.rs1);
    assign src2_addr_s = rf_addr(s1_q.hart, s1_q.rs2);
    assign dst_addr_s  = rf_addr(s1_q.hart, s1_q.rd);
    assign nonzero_s   = {s1_q.rd != X0, s1_q.rs2 != X0, s1_q.rs1 != X0};
    assign hazard_s    = s1_valid_q && (|(busy_s & nonzero_s));
    assign out_valid   = s1_valid_q && !hazard_s;
    assign issue_s     = out_valid && out_ready;
    assign in_ready    = !s1_valid_q || issue_s;
    assign accept_s    = reset_n && in_valid && in_ready;

    operand_scoreboard u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .set_en_i     (issue_s && (s1_q.rd != X0)),
        .set_addr_i   (dst_addr_s),
        .clr_en_i     (wren_s),
        .clr_addr_i   (wb_addr_s),
        .look0_addr_i (src1_addr_s),
        .look1_addr_i (src2_addr_s),
        .look2_addr_i (dst_addr_s),
        .busy_o       (busy_s)
    );

    // Regfile request: read the incoming instruction on accept, otherwise keep re-reading S1.
    always_comb begin
        rf_req = '0;
        if (reset_n) begin
            rf_req.raddr1 = accept_s ? rf_addr(in_hart, in_rs1) : src1_addr_s;
            rf_req.raddr2 = accept_s ? rf_addr(in_hart, in_rs2) : src2_addr_s;
            rf_req.waddr  = wb_addr_s;
            rf_req.wdata  = wb_data;
            rf_req.wren   = wren_s;
        end else begin
            rf_req = '0;
        end
    end

    // Instruction slot: load on accept, empty on issue without a replacement.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (accept_s) begin
            s1_valid_q <= 1'b1;
            s1_q       <= '{hart: in_hart, rs1: in_rs1, rs2: in_rs2, rd: in_rd, pc: in_pc};
        end else if (issue_s) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_q;
        end
    end

    // A write landing on the same edge as the regfile read may not be visible in
    // the returned data; remember it so the next cycle can substitute the value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            late1_q     <= 1'b0;
            late2_q     <= 1'b0;
            late_data_q <= {XLEN{1'b0}};
        end else begin
            late1_q     <= wren_s && (wb_addr_s == rf_req.raddr1);
            late2_q     <= wren_s && (wb_addr_s == rf_req.raddr2);
            late_data_q <= wb_data;
        end
    end

    // Per-source operand selection: x0, current writeback, edge-raced writeback, regfile.
    always_comb begin
        fwd1_s = rf_rs1;
        if (s1_q.rs1 == X0) begin
            fwd1_s = {XLEN{1'b0}};
        end else if (wren_s && (wb_addr_s == src1_addr_s)) begin
            fwd1_s = wb_data;
        end else if (late1_q) begin
            fwd1_s = late_data_q;
        end else begin
            fwd1_s = rf_rs1;
        end
        fwd2_s = rf_rs2;
        if (s1_q.rs2 == X0) begin
            fwd2_s = {XLEN{1'b0}};
        end else if (wren_s && (wb_addr_s == src2_addr_s)) begin
            fwd2_s = wb_data;
        end else if (late2_q) begin
            fwd2_s = late_data_q;
        end else begin
            fwd2_s = rf_rs2;
        end
    end

    // Downstream payload, held at zero whenever no instruction is offered.
    always_comb begin
        if (out_valid) begin
            out_hart     = s1_q.hart;
            out_rd       = s1_q.rd;
            out_pc       = s1_q.pc;
            out_rs1_data = fwd1_s;
            out_rs2_data = fwd2_s;
        end else begin
            out_hart     = {HART_BITS{1'b0}};
            out_rd       = X0;
            out_pc       = 32'h0;
            out_rs1_data = {XLEN{1'b0}};
            out_rs2_data = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic,
// checked every cycle against an architectural model of registers and hazards.
module tb_operand_fetch;
    import pinwheel_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_hart;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_pc;
    logic        wb_valid;
    logic [2:0]  wb_hart;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    regfile_in   rf_req;
    logic [31:0] rf_rs1 = 32'h0;
    logic [31:0] rf_rs2 = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_hart;
    logic [4:0]  out_rd;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data;

    always #5 clock = ~clock;

    operand_fetch dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_hart(in_hart),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_pc(in_pc),
        .wb_valid(wb_valid), .wb_hart(wb_hart), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_req(rf_req), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_hart(out_hart),
        .out_rd(out_rd), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
    );

    // Environment regfile: registered reads that return the pre-write value on a collision.
    logic [31:0] rf_mem [NUM_REGS] = '{default: 32'h0};
    always @(posedge clock) begin
        rf_rs1 <= rf_mem[rf_req.raddr1];
        rf_rs2 <= rf_mem[rf_req.raddr2];
        if (rf_req.wren) rf_mem[rf_req.waddr] <= rf_req.wdata;
    end

    // Architectural model
    logic [31:0] arch   [NUM_REGS];
    bit          pend_m [NUM_REGS];
    bit          m_s1v;
    logic [2:0]  m_hart;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_pc;
    bit          e_wr, e_iss, e_acc;
    logic [7:0]  e_wa;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ad(input logic [2:0] h, input logic [4:0] r);
        return {h, r};
    endfunction

    function automatic bit busy_m(input logic [4:0] r, input logic [7:0] a);
        return (r != 5'd0) && pend_m[a] && !(e_wr && (e_wa == a));
    endfunction

    function automatic logic [31:0] val_m(input logic [4:0] r, input logic [7:0] a);
        if (r == 5'd0) return 32'h0;
        if (e_wr && (e_wa == a)) return wb_data;
        return arch[a];
    endfunction

    task automatic model_reset();
        m_s1v = 1'b0; m_hart = 3'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_pc = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) pend_m[i] = 1'b0;
    endtask

    // Compare all outputs against the model in the middle of the cycle.
    task automatic settle();
        bit hz, ov, ir;
        @(negedge clock);
        if (!reset_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_wren", 32'(rf_req.wren), 32'd0);
            chk("rst_raddr", {16'h0, rf_req.raddr1, rf_req.raddr2}, 32'h0);
            chk("rst_waddr", 32'(rf_req.waddr), 32'h0);
            chk("rst_wdata", rf_req.wdata, 32'h0);
            chk("rst_out_rs1", out_rs1_data, 32'h0);
        end else begin
            e_wr  = wb_valid && (wb_rd != 5'd0);
            e_wa  = ad(wb_hart, wb_rd);
            hz    = m_s1v && (busy_m(m_rs1, ad(m_hart, m_rs1)) || busy_m(m_rs2, ad(m_hart, m_rs2))
                              || busy_m(m_rd, ad(m_hart, m_rd)));
            ov    = m_s1v && !hz;
            e_iss = ov && out_ready;
            ir    = !m_s1v || e_iss;
            e_acc = in_valid && ir;
            chk("in_ready", 32'(in_ready), 32'(ir));
            chk("out_valid", 32'(out_valid), 32'(ov));
            chk("wren", 32'(rf_req.wren), 32'(e_wr));
            if (e_wr) begin
                chk("waddr", 32'(rf_req.waddr), 32'(e_wa));
                chk("wdata", rf_req.wdata, wb_data);
            end
            chk("raddr1", 32'(rf_req.raddr1), 32'(e_acc ? ad(in_hart, in_rs1) : ad(m_hart, m_rs1)));
            chk("raddr2", 32'(rf_req.raddr2), 32'(e_acc ? ad(in_hart, in_rs2) : ad(m_hart, m_rs2)));
            chk("out_hart", 32'(out_hart), ov ? 32'(m_hart) : 32'd0);
            chk("out_rd", 32'(out_rd), ov ? 32'(m_rd) : 32'd0);
            chk("out_pc", out_pc, ov ? m_pc : 32'h0);
            chk("out_rs1_data", out_rs1_data, ov ? val_m(m_rs1, ad(m_hart, m_rs1)) : 32'h0);
            chk("out_rs2_data", out_rs2_data, ov ? val_m(m_rs2, ad(m_hart, m_rs2)) : 32'h0);
        end
    endtask

    // Advance the model across the clock edge, then let the DUT settle.
    task automatic adv();
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (e_wr) begin
                arch[e_wa]   = wb_data;
                pend_m[e_wa] = 1'b0;
            end
            if (e_iss && (m_rd != 5'd0)) pend_m[ad(m_hart, m_rd)] = 1'b1;
            if (e_acc) begin
                m_s1v = 1'b1; m_hart = in_hart; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_pc = in_pc;
            end else if (e_iss) begin
                m_s1v = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic drv_in(input bit v, input int h, input int r1, input int r2, input int rd, input logic [31:0] pc);
        in_valid = v; in_hart = 3'(h); in_rs1 = 5'(r1); in_rs2 = 5'(r2); in_rd = 5'(rd); in_pc = pc;
    endtask

    task automatic drv_wb(input bit v, input int h, input int rd, input logic [31:0] d);
        wb_valid = v; wb_hart = 3'(h); wb_rd = 5'(rd); wb_data = d;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) arch[i] = 32'h0;
        model_reset();
        e_wr = 1'b0; e_iss = 1'b0; e_acc = 1'b0; e_wa = 8'h0;
        reset_n = 1'b0; out_ready = 1'b1;
        drv_in(1'b0, 0, 0, 0, 0, 32'h0);
        drv_wb(1'b0, 0, 0, 32'h0);
        cyc(); cyc();
        reset_n = 1'b1;

        // Preload and single read.
        drv_wb(1'b1, 2, 5, 32'h1234_5678); cyc();
        drv_wb(1'b0, 0, 0, 32'h0); drv_in(1'b1, 2, 5, 0, 0, 32'h100); cyc();
        drv_in(1'b0, 0, 0, 0, 0, 32'h0); settle();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_rs1", out_rs1_data, 32'h1234_5678);
        chk("t1_rs2", out_rs2_data, 32'h0);
        adv();

        // x0 is never written.
        drv_wb(1'b1, 1, 0, 32'hFFFF_FFFF); settle();
        chk("x0_wren", 32'(rf_req.wren), 32'd0);
        adv();
        drv_wb(1'b0, 0, 0, 32'h0);

        // RAW stall released by writeback, forwarded the same cycle.
        drv_in(1'b1, 1, 0, 0, 7, 32'h200); cyc();
        drv_in(1'b1, 1, 7, 0, 0, 32'h204); cyc();
        drv_in(1'b0, 0, 0, 0, 0, 32'h0); settle();
        chk("raw_stall_valid", 32'(out_valid), 32'd0);
        chk("raw_stall_ready", 32'(in_ready), 32'd0);
        adv();
        cyc();
        drv_wb(1'b1, 1, 7, 32'hDEAD_BEEF); settle();
        chk("raw_fwd_valid", 32'(out_valid), 32'd1);
        chk("raw_fwd_rs1", out_rs1_data, 32'hDEAD_BEEF);
        adv();
        drv_wb(1'b0, 0, 0, 32'h0);

        // Backpressure with a write landing during the stall.
        out_ready = 1'b0; drv_in(1'b1, 0, 0, 3, 0, 32'h300); cyc();
        drv_in(1'b0, 0, 0, 0, 0, 32'h0); drv_wb(1'b1, 0, 3, 32'h55); settle();
        chk("bp_ready0", 32'(in_ready), 32'd0);
        adv();
        drv_wb(1'b0, 0, 0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_rs2_hold", out_rs2_data, 32'h55);
            adv();
        end
        out_ready = 1'b1; settle();
        chk("bp_issue_valid", 32'(out_valid), 32'd1);
        chk("bp_issue_rs2", out_rs2_data, 32'h55);
        adv();

        // Hart isolation: hart0 x4 pending must not stall hart3 x4.
        drv_wb(1'b1, 3, 4, 32'h3333); cyc();
        drv_wb(1'b0, 0, 0, 32'h0); drv_in(1'b1, 0, 0, 0, 4, 32'h400); cyc();
        drv_in(1'b1, 3, 4, 0, 0, 32'h404); cyc();
        drv_in(1'b0, 0, 0, 0, 0, 32'h0); settle();
        chk("iso_valid", 32'(out_valid), 32'd1);
        chk("iso_rs1", out_rs1_data, 32'h3333);
        adv();
        drv_wb(1'b1, 0, 4, 32'h44); cyc();
        drv_wb(1'b0, 0, 0, 32'h0);

        // Set and clear of the same bit in one cycle: set wins.
        drv_in(1'b1, 0, 0, 0, 9, 32'h500); cyc();
        drv_in(1'b1, 0, 9, 0, 0, 32'h504); drv_wb(1'b1, 0, 9, 32'h99); cyc();
        drv_in(1'b0, 0, 0, 0, 0, 32'h0); drv_wb(1'b0, 0, 0, 32'h0); settle();
        chk("sc_stall", 32'(out_valid), 32'd0);
        adv();
        cyc();

        // Reset in the middle of the stall.
        reset_n = 1'b0; #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        cyc();
        reset_n = 1'b1;
        drv_in(1'b1, 0, 9, 0, 0, 32'h600); cyc();
        drv_in(1'b0, 0, 0, 0, 0, 32'h0); settle();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_rs1", out_rs1_data, 32'h99);
        adv();

        // Random traffic on a small register window to provoke hazards.
        repeat (3000) begin
            drv_in($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            drv_wb($urandom_range(0, 9) < 4, $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
            out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
